if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 18 +
 rtl/if_stage_if.sv | 24 ++
 rtl/if_stage_pc_reg.sv | 37 +++
 rtl/if_stage.sv | 69 ++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction fetch stage.
package if_stage_pkg;

    localparam logic [15:0] NOP          = 16'h0000;
    localparam logic [15:0] PC_INC       = 16'd2;
    localparam logic [15:0] RESET_VECTOR = 16'h0000;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Sequential fetch address; wraps modulo 2^16 with no carry out.
    function automatic logic [15:0] pc_plus(input logic [15:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's pipeline, hazard and instruction-memory signals.
interface if_stage_if;

    logic        PCStall;
    logic        BranchTaken;
    logic [15:0] BranchTarget;
    logic [15:0] ImemAddr;
    logic [15:0] ImemData;
    logic [15:0] IFID;
    logic [15:0] IFIDPC;
    logic        IFIDValid;
    logic [7:0]  StallCount;

    modport master (
        input  PCStall, BranchTaken, BranchTarget, ImemData,
        output ImemAddr, IFID, IFIDPC, IFIDValid, StallCount
    );

    modport slave (
        output PCStall, BranchTaken, BranchTarget, ImemData,
        input  ImemAddr, IFID, IFIDPC, IFIDValid, StallCount
    );

endinterface

// File: rtl/if_stage_pc_reg.sv
// Program counter with boot, redirect, hold and sequential-increment selection.
module pc_reg
    import if_stage_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        boot,
    input  logic        hold,
    input  logic        redirect,
    input  logic [15:0] target,
    output logic [15:0] pc
);

    logic [15:0] next_pc;

    // Next-PC priority: boot pins the reset vector, redirect beats hold, else step by PC_INC.
    always_comb begin
        next_pc = pc_plus(pc);
        if (boot) begin
            next_pc = RESET_VECTOR;
        end else if (redirect) begin
            next_pc = target & 16'hFFFE;
        end else if (hold) begin
            next_pc = pc;
        end
    end

    // PC register with synchronous reset to the reset vector.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= RESET_VECTOR;
        end else begin
            pc <= next_pc;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, IF/ID pipeline register, boot FSM and stall counter.
module if_stage
    import if_stage_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    if_stage_if.master bus
);

    state_t      state;
    logic [15:0] pc;
    logic        in_run;
    logic        redirect;
    logic        stall;

    assign in_run   = (state == RUN);
    assign redirect = in_run && bus.BranchTaken;
    assign stall    = in_run && bus.PCStall && !bus.BranchTaken;

    assign bus.ImemAddr = pc;

    pc_reg u_pc_reg (
        .clock    (clock),
        .reset    (reset),
        .boot     (!in_run),
        .hold     (stall),
        .redirect (redirect),
        .target   (bus.BranchTarget),
        .pc       (pc)
    );

    // Boot FSM: one BOOT cycle after reset, then RUN until the next reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            case (state)
                BOOT:    state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    // IF/ID register: bubble on boot or redirect, freeze on stall, otherwise capture the fetch.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.IFID      <= NOP;
            bus.IFIDPC    <= RESET_VECTOR;
            bus.IFIDValid <= 1'b0;
        end else if (!in_run || redirect) begin
            bus.IFID      <= NOP;
            bus.IFIDValid <= 1'b0;
        end else if (!stall) begin
            bus.IFID      <= bus.ImemData;
            bus.IFIDPC    <= pc_plus(pc);
            bus.IFIDValid <= 1'b1;
        end
    end

    // Saturating count of cycles lost to a stall that no redirect overrode.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.StallCount <= 8'h00;
        end else if (stall && bus.StallCount != 8'hFF) begin
            bus.StallCount <= bus.StallCount + 8'h01;
        end
    end

endmodule
